mips_multicycle_control: RTL and testbench
==========================================

// Module: mips_multicycle_control
// PURPOSE
// - Control FSM for the multicycle MIPS datapath: decodes opcode/funct from the instruction register
//   and sequences fetch/decode/execute/memory/writeback, one state per cycle.
// - Drives every datapath enable and mux select (pc_en, ir_write, memory/RF enables, ALU controls).
// - Supports R-type add/sub/and/or/slt, lw, sw, beq, bne, addi, j; flags anything else as illegal.
// PARAMETERS
// - USE_MEM_READY  1  1: FETCH/MEMREAD/MEMWRITE wait for mem_ready; 0: mem_ready ignored (treated as 1)
// PORTS
// - clk          input   1  clock, all state updates on rising edge
// - rst          input   1  asynchronous, active-low reset
// - opcode       input   6  instr[31:26] from instruction register
// - funct        input   6  instr[5:0] from instruction register
// - alu_zero     input   1  ALU zero flag, valid in BRANCH state
// - mem_ready    input   1  memory access completes this cycle
// - pc_en        output  1  PC load enable
// - ir_write     output  1  instruction register load enable
// - iord         output  1  memory address select: 0 = PC, 1 = ALU result register
// - mem_rd_en    output  1  data-port read enable
// - mem_wr_en    output  1  data-port write enable
// - rf_wr_en     output  1  register-file write enable
// - reg_dst      output  1  RF write address: 0 = rt, 1 = rd
// - mem_to_reg   output  1  RF write data: 0 = ALU result register, 1 = memory data register
// - alu_src_a    output  1  0 = PC, 1 = rf_rd_data_0_q
// - alu_src_b    output  2  00 = B reg, 01 = const 4, 10 = sign_imm, 11 = sign_imm<<2
// - alu_ctrl     output  3  010 add, 110 sub, 000 and, 001 or, 111 slt
// - pc_src       output  2  00 = ALU out, 01 = ALU result register, 10 = jump target
// - illegal_instr output 1  one-cycle pulse in DECODE for unsupported opcode/funct
// - instr_done   output  1  one-cycle pulse on the final cycle of every instruction
// BEHAVIOUR
// - State register only; all outputs combinational from state (+opcode/funct/alu_zero/mem_ready).
// - rst low: state <= FETCH asynchronously; while rst low every enable output (pc_en, ir_write,
//   mem_rd_en, mem_wr_en, rf_wr_en, illegal_instr, instr_done) forced 0; selects = 0, alu_ctrl = 010.
// - Outputs not listed for a state: enables 0, selects 0, alu_ctrl 010.
// - FETCH: iord=0, alu_src_a=0, alu_src_b=01, add, pc_src=00; ir_write=pc_en=mem_ready.
//   Stay until mem_ready, then -> DECODE. PC+4 and IR load happen on the same edge.
// - DECODE: alu_src_a=0, alu_src_b=11, add (branch target). lw/sw->MEMADR, R->EXECUTE,
//   beq/bne->BRANCH, addi->ADDIEXEC, j->JUMP; unknown opcode or R-type unknown funct ->
//   illegal_instr=1, instr_done=1, -> FETCH (instruction skipped, PC already advanced).
// - MEMADR: alu_src_a=1, alu_src_b=10, add. lw->MEMREAD, sw->MEMWRITE.
// - MEMREAD: iord=1, mem_rd_en=1; wait for mem_ready, then -> MEMWB.
// - MEMWB: rf_wr_en=1, reg_dst=0, mem_to_reg=1, instr_done=1 -> FETCH.
// - MEMWRITE: iord=1, mem_wr_en=1 held until mem_ready; instr_done=mem_ready; -> FETCH on mem_ready.
//   mem_wr_en must not drop before mem_ready (write data/address stable throughout).
// - EXECUTE: alu_src_a=1, alu_src_b=00, alu_ctrl from funct decode -> ALUWB.
// - ALUWB: rf_wr_en=1, reg_dst=1, mem_to_reg=0, instr_done=1 -> FETCH.
// - BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_src=01; pc_en = beq ? alu_zero : ~alu_zero;
//   instr_done=1 -> FETCH.
// - ADDIEXEC: alu_src_a=1, alu_src_b=10, add -> ADDIWB. ADDIWB: rf_wr_en=1, reg_dst=0,
//   mem_to_reg=0, instr_done=1 -> FETCH.
// - JUMP: pc_src=10, pc_en=1, instr_done=1 -> FETCH.
// - Never more than one of mem_rd_en/mem_wr_en/ir_write(data port) active; rf_wr_en and
//   mem_wr_en never high together. Latencies (mem_ready=1 always): R/addi 4, lw 5, sw 4,
//   branch 3, j 3, illegal 2 cycles.
// - Reset mid-instruction abandons it: no partial write enables issued after rst falls.
// - Unreachable state encodings recover to FETCH on next edge with all enables 0.
// STRUCTURE
// - mips_pkg: opcode/funct localparams, state_t enum, alu_ctrl_t enum, alu_src_b/pc_src encodings.
// - Sub-module mips_alu_decoder: (alu_op[1:0], funct) -> alu_ctrl, funct_illegal; combinational.
// TESTING
// - rst low mid-MEMWRITE, opcode=101011 -> mem_wr_en drops same cycle, state FETCH after release.
// - add (op 0, funct 100000), mem_ready=1 -> states FETCH,DECODE,EXECUTE,ALUWB; rf_wr_en,reg_dst=1 cycle 4.
// - lw (100011), mem_ready low 3 cycles in MEMREAD -> mem_rd_en held 4 cycles, MEMWB next, 8 total.
// - beq (000100) alu_zero=1 -> pc_en=1 pc_src=01 in BRANCH; bne (000101) alu_zero=1 -> pc_en=0.
// - opcode 111111 -> illegal_instr & instr_done pulse in DECODE, back to FETCH, rf_wr_en never high.
// - USE_MEM_READY=0, mem_ready=0, sw (101011) -> completes in 4 cycles, instr_done once.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS control path: opcodes, functs,
// FSM states, ALU control codes and datapath mux selects.
package mips_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10,
    S_JUMP     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_AND = 3'b000,
    ALU_OR  = 3'b001,
    ALU_ADD = 3'b010,
    ALU_SUB = 3'b110,
    ALU_SLT = 3'b111
  } alu_ctrl_t;

  // What the FSM asks of the ALU decoder: fixed add, fixed sub, or decode funct
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // alu_src_b selects
  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // pc_src selects
  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Maps the FSM's ALU request plus the R-type funct field onto an ALU
// control code. funct_illegal flags a funct outside the supported set and
// is meaningful only for R-type instructions.
module mips_alu_decoder
  import mips_pkg::*;
(
  input  alu_op_t    alu_op,
  input  logic [5:0] funct,
  output alu_ctrl_t  alu_ctrl,
  output logic       funct_illegal
);

  alu_ctrl_t fn_ctrl;

  // Decode funct independently of alu_op, then pick the final control code
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
    fn_ctrl       = ALU_ADD;
    funct_illegal = 1'b0;
    case (funct)
      FN_ADD:  fn_ctrl = ALU_ADD;
      FN_SUB:  fn_ctrl = ALU_SUB;
      FN_AND:  fn_ctrl = ALU_AND;
      FN_OR:   fn_ctrl = ALU_OR;
      FN_SLT:  fn_ctrl = ALU_SLT;
      default: funct_illegal = 1'b1;
    endcase

    alu_ctrl = ALU_ADD;
    case (alu_op)
      ALU_OP_SUB:   alu_ctrl = ALU_SUB;
      ALU_OP_FUNCT: alu_ctrl = fn_ctrl;
      default:      alu_ctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_control.sv
// Control FSM for the multicycle MIPS datapath. One state per cycle; every
// output is a combinational function of the state and the instruction
// fields, and is forced to its idle value while reset is asserted.
module mips_multicycle_control
  import mips_pkg::*;
#(
  parameter int USE_MEM_READY = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       ir_write,
  output logic       iord,
  output logic       mem_rd_en,
  output logic       mem_wr_en,
  output logic       rf_wr_en,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_ctrl,
  output logic [1:0] pc_src,
  output logic       illegal_instr,
  output logic       instr_done
);

  state_t    state_q, state_d;
  alu_op_t   alu_op;
  alu_ctrl_t dec_ctrl;
  logic      funct_illegal;
  logic      mem_rdy;

  // Without a handshake the memory is assumed to complete every access in one cycle
  assign mem_rdy = (USE_MEM_READY != 0) ? mem_ready : 1'b1;

  mips_alu_decoder u_alu_decoder (
    .alu_op        (alu_op),
    .funct         (funct),
    .alu_ctrl      (dec_ctrl),
    .funct_illegal (funct_illegal)
  );

  assign alu_ctrl = dec_ctrl;

  // State register; reset returns to FETCH immediately
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignment so all flops update together at the edge.
    if (!rst) state_q <= S_FETCH;
    else      state_q <= state_d;
  end

  // ALU request per state; reset holds it at add so alu_ctrl idles at 010
  always_comb begin
    alu_op = ALU_OP_ADD;
    if (rst) begin
      case (state_q)
        S_EXECUTE: alu_op = ALU_OP_FUNCT;
        S_BRANCH:  alu_op = ALU_OP_SUB;
        default:   alu_op = ALU_OP_ADD;
      endcase
    end
  end

  // Next-state and datapath controls
  always_comb begin
    state_d       = state_q;
    pc_en         = 1'b0;
    ir_write      = 1'b0;
    iord          = 1'b0;
    mem_rd_en     = 1'b0;
    mem_wr_en     = 1'b0;
    rf_wr_en      = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    alu_src_a     = 1'b0;
    alu_src_b     = SRCB_REG;
    pc_src        = PC_SRC_ALU;
    illegal_instr = 1'b0;
    instr_done    = 1'b0;

    case (state_q)
      S_FETCH: begin
        alu_src_b = SRCB_FOUR;
        ir_write  = mem_rdy;
        pc_en     = mem_rdy;
        if (mem_rdy) state_d = S_DECODE;
      end
      S_DECODE: begin
        alu_src_b = SRCB_IMM_SH2;
        case (opcode)
          OP_LW, OP_SW:   state_d = S_MEMADR;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_ADDI:        state_d = S_ADDIEXEC;
          OP_J:           state_d = S_JUMP;
          OP_RTYPE: begin
            if (funct_illegal) begin
              illegal_instr = 1'b1;
              instr_done    = 1'b1;
              state_d       = S_FETCH;
            end else begin
              state_d = S_EXECUTE;
            end
          end
          default: begin
            illegal_instr = 1'b1;
            instr_done    = 1'b1;
            state_d       = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        iord      = 1'b1;
        mem_rd_en = 1'b1;
        if (mem_rdy) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        rf_wr_en   = 1'b1;
        mem_to_reg = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_MEMWRITE: begin
        // Write enable stays up until the memory accepts, keeping address/data stable
        iord       = 1'b1;
        mem_wr_en  = 1'b1;
        instr_done = mem_rdy;
        if (mem_rdy) state_d = S_FETCH;
      end
      S_EXECUTE: begin
        alu_src_a = 1'b1;
        state_d   = S_ALUWB;
      end
      S_ALUWB: begin
        rf_wr_en   = 1'b1;
        reg_dst    = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_BRANCH: begin
        alu_src_a  = 1'b1;
        pc_src     = PC_SRC_ALUOUT;
        pc_en      = (opcode == OP_BEQ) ? alu_zero : ~alu_zero;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_ADDIEXEC: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = S_ADDIWB;
      end
      S_ADDIWB: begin
        rf_wr_en   = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      S_JUMP: begin
        pc_src     = PC_SRC_JUMP;
        pc_en      = 1'b1;
        instr_done = 1'b1;
        state_d    = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase

    // Reset abandons the current instruction: no enables, selects idle
    if (!rst) begin
      pc_en         = 1'b0;
      ir_write      = 1'b0;
      iord          = 1'b0;
      mem_rd_en     = 1'b0;
      mem_wr_en     = 1'b0;
      rf_wr_en      = 1'b0;
      reg_dst       = 1'b0;
      mem_to_reg    = 1'b0;
      alu_src_a     = 1'b0;
      alu_src_b     = SRCB_REG;
      pc_src        = PC_SRC_ALU;
      illegal_instr = 1'b0;
      instr_done    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Directed bench for mips_multicycle_control: walks each instruction class
// cycle by cycle and compares the full control vector and state against
// hand-written expectations.
module tb_mips_multicycle_control;
  import mips_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic [5:0] funct = 6'd0;
  logic       alu_zero = 1'b0;
  logic       mem_ready = 1'b1;

  // Outputs of the handshake instance
  logic       pc_en, ir_write, iord, mem_rd_en, mem_wr_en, rf_wr_en;
  logic       reg_dst, mem_to_reg, alu_src_a, illegal_instr, instr_done;
  logic [1:0] alu_src_b, pc_src;
  logic [2:0] alu_ctrl;

  // Outputs of the no-handshake instance
  logic       pc_en_b, ir_write_b, iord_b, mem_rd_en_b, mem_wr_en_b, rf_wr_en_b;
  logic       reg_dst_b, mem_to_reg_b, alu_src_a_b, illegal_instr_b, instr_done_b;
  logic [1:0] alu_src_b_b, pc_src_b;
  logic [2:0] alu_ctrl_b;

  int errors = 0;
  int checks = 0;
  int done_cnt;

  always #5 clk = ~clk;

  mips_multicycle_control #(.USE_MEM_READY(1)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .ir_write(ir_write), .iord(iord),
    .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .rf_wr_en(rf_wr_en),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a),
    .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .pc_src(pc_src),
    .illegal_instr(illegal_instr), .instr_done(instr_done)
  );

  mips_multicycle_control #(.USE_MEM_READY(0)) dut_nr (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct),
    .alu_zero(alu_zero), .mem_ready(mem_ready),
    .pc_en(pc_en_b), .ir_write(ir_write_b), .iord(iord_b),
    .mem_rd_en(mem_rd_en_b), .mem_wr_en(mem_wr_en_b), .rf_wr_en(rf_wr_en_b),
    .reg_dst(reg_dst_b), .mem_to_reg(mem_to_reg_b), .alu_src_a(alu_src_a_b),
    .alu_src_b(alu_src_b_b), .alu_ctrl(alu_ctrl_b), .pc_src(pc_src_b),
    .illegal_instr(illegal_instr_b), .instr_done(instr_done_b)
  );

  logic [17:0] act, act_b;
  assign act   = {pc_en, ir_write, iord, mem_rd_en, mem_wr_en, rf_wr_en, reg_dst,
                  mem_to_reg, alu_src_a, alu_src_b, alu_ctrl, pc_src, illegal_instr, instr_done};
  assign act_b = {pc_en_b, ir_write_b, iord_b, mem_rd_en_b, mem_wr_en_b, rf_wr_en_b, reg_dst_b,
                  mem_to_reg_b, alu_src_a_b, alu_src_b_b, alu_ctrl_b, pc_src_b, illegal_instr_b,
                  instr_done_b};

  // Packs hand-written control values into the same layout as act
  function automatic logic [17:0] cv(
    input logic pce, input logic irw, input logic io, input logic rd, input logic wr,
    input logic rfw, input logic rdst, input logic m2r, input logic asa,
    input logic [1:0] asb, input logic [2:0] actl, input logic [1:0] pcs,
    input logic ill, input logic done);
    return {pce, irw, io, rd, wr, rfw, rdst, m2r, asa, asb, actl, pcs, ill, done};
  endfunction

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, actual, expected);
    end
  endtask

  // One clock cycle: inputs are already driven; compare at the falling edge,
  // then advance to just after the next rising edge.
  task automatic cyc(input string tag, input logic [17:0] exp_v, input state_t exp_s,
                     input bit use_nr = 1'b0);
    @(negedge clk);
    if (use_nr) begin
      check({tag, " ctl"}, 32'(act_b), 32'(exp_v));
      check({tag, " st"}, 32'(dut_nr.state_q), 32'(exp_s));
      if (instr_done_b) done_cnt++;
    end else begin
      check({tag, " ctl"}, 32'(act), 32'(exp_v));
      check({tag, " st"}, 32'(dut.state_q), 32'(exp_s));
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Expected control vectors (hand-derived from the state descriptions)
  logic [17:0] v_rst, v_f1, v_f0, v_dec, v_ill, v_exe_add, v_exe_sub, v_exe_slt, v_aluwb;
  logic [17:0] v_ma, v_mr, v_mwb, v_mw0, v_mw1, v_br1, v_br0, v_jmp, v_aex, v_awb;

  initial begin
    v_rst     = cv(0,0,0,0,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
    v_f1      = cv(1,1,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
    v_f0      = cv(0,0,0,0,0,0,0,0,0,2'b01,3'b010,2'b00,0,0);
    v_dec     = cv(0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,0,0);
    v_ill     = cv(0,0,0,0,0,0,0,0,0,2'b11,3'b010,2'b00,1,1);
    v_exe_add = cv(0,0,0,0,0,0,0,0,1,2'b00,3'b010,2'b00,0,0);
    v_exe_sub = cv(0,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b00,0,0);
    v_exe_slt = cv(0,0,0,0,0,0,0,0,1,2'b00,3'b111,2'b00,0,0);
    v_aluwb   = cv(0,0,0,0,0,1,1,0,0,2'b00,3'b010,2'b00,0,1);
    v_ma      = cv(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
    v_mr      = cv(0,0,1,1,0,0,0,0,0,2'b00,3'b010,2'b00,0,0);
    v_mwb     = cv(0,0,0,0,0,1,0,1,0,2'b00,3'b010,2'b00,0,1);
    v_mw0     = cv(0,0,1,0,1,0,0,0,0,2'b00,3'b010,2'b00,0,0);
    v_mw1     = cv(0,0,1,0,1,0,0,0,0,2'b00,3'b010,2'b00,0,1);
    v_br1     = cv(1,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1);
    v_br0     = cv(0,0,0,0,0,0,0,0,1,2'b00,3'b110,2'b01,0,1);
    v_jmp     = cv(1,0,0,0,0,0,0,0,0,2'b00,3'b010,2'b10,0,1);
    v_aex     = cv(0,0,0,0,0,0,0,0,1,2'b10,3'b010,2'b00,0,0);
    v_awb     = cv(0,0,0,0,0,1,0,0,0,2'b00,3'b010,2'b00,0,1);

    // Reset: outputs idle even though FETCH would otherwise enable pc/ir
    opcode = OP_SW; mem_ready = 1'b1;
    #2;
    check("rst ctl", 32'(act), 32'(v_rst));
    check("rst st", 32'(dut.state_q), 32'(S_FETCH));
    do_reset();

    // add: 4 cycles, write-back to rd on the last
    opcode = OP_RTYPE; funct = FN_ADD;
    cyc("add f", v_f1, S_FETCH);
    cyc("add d", v_dec, S_DECODE);
    cyc("add e", v_exe_add, S_EXECUTE);
    cyc("add wb", v_aluwb, S_ALUWB);

    // sub and slt: funct decode reaches alu_ctrl in EXECUTE
    funct = FN_SUB;
    cyc("sub f", v_f1, S_FETCH);
    cyc("sub d", v_dec, S_DECODE);
    cyc("sub e", v_exe_sub, S_EXECUTE);
    cyc("sub wb", v_aluwb, S_ALUWB);
    funct = FN_SLT;
    cyc("slt f", v_f1, S_FETCH);
    cyc("slt d", v_dec, S_DECODE);
    cyc("slt e", v_exe_slt, S_EXECUTE);
    cyc("slt wb", v_aluwb, S_ALUWB);

    // lw with memory stalling 3 cycles in MEMREAD: 8 cycles total
    opcode = OP_LW; funct = 6'd0;
    cyc("lw f", v_f1, S_FETCH);
    cyc("lw d", v_dec, S_DECODE);
    cyc("lw ma", v_ma, S_MEMADR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc($sformatf("lw mr%0d", i), v_mr, S_MEMREAD);
    mem_ready = 1'b1;
    cyc("lw mr3", v_mr, S_MEMREAD);
    cyc("lw wb", v_mwb, S_MEMWB);

    // FETCH stalls without mem_ready
    opcode = OP_J; mem_ready = 1'b0;
    cyc("stall f", v_f0, S_FETCH);
    mem_ready = 1'b1;
    cyc("j f", v_f1, S_FETCH);
    cyc("j d", v_dec, S_DECODE);
    cyc("j j", v_jmp, S_JUMP);

    // Branches
    opcode = OP_BEQ; alu_zero = 1'b1;
    cyc("beq f", v_f1, S_FETCH);
    cyc("beq d", v_dec, S_DECODE);
    cyc("beq taken", v_br1, S_BRANCH);
    opcode = OP_BNE;
    cyc("bne f", v_f1, S_FETCH);
    cyc("bne d", v_dec, S_DECODE);
    cyc("bne nt", v_br0, S_BRANCH);
    alu_zero = 1'b0;
    cyc("bne2 f", v_f1, S_FETCH);
    cyc("bne2 d", v_dec, S_DECODE);
    cyc("bne taken", v_br1, S_BRANCH);

    // addi
    opcode = OP_ADDI;
    cyc("addi f", v_f1, S_FETCH);
    cyc("addi d", v_dec, S_DECODE);
    cyc("addi ex", v_aex, S_ADDIEXEC);
    cyc("addi wb", v_awb, S_ADDIWB);

    // Illegal opcode and illegal R-type funct: 2 cycles, no RF write
    opcode = 6'b111111;
    cyc("ill f", v_f1, S_FETCH);
    cyc("ill d", v_ill, S_DECODE);
    opcode = OP_RTYPE; funct = 6'b001000;
    cyc("illfn f", v_f1, S_FETCH);
    cyc("illfn d", v_ill, S_DECODE);
    cyc("ill back", v_f1, S_FETCH);

    // sw held in MEMWRITE, then reset mid-write
    opcode = OP_SW; funct = 6'd0;
    cyc("sw d", v_dec, S_DECODE);
    cyc("sw ma", v_ma, S_MEMADR);
    mem_ready = 1'b0;
    cyc("sw hold0", v_mw0, S_MEMWRITE);
    cyc("sw hold1", v_mw0, S_MEMWRITE);
    #2;
    rst = 1'b0;
    #1;
    check("rstmid wr_en", 32'(mem_wr_en), 32'd0);
    check("rstmid ctl", 32'(act), 32'(v_rst));
    check("rstmid st", 32'(dut.state_q), 32'(S_FETCH));
    @(posedge clk);
    #1;
    rst = 1'b1;
    mem_ready = 1'b1;
    cyc("after rst f", v_f1, S_FETCH);
    cyc("sw2 d", v_dec, S_DECODE);
    cyc("sw2 ma", v_ma, S_MEMADR);
    cyc("sw2 mw", v_mw1, S_MEMWRITE);

    // No-handshake instance: sw completes in 4 cycles with mem_ready low
    do_reset();
    opcode = OP_SW; mem_ready = 1'b0; done_cnt = 0;
    cyc("nr f", v_f1, S_FETCH, 1'b1);
    cyc("nr d", v_dec, S_DECODE, 1'b1);
    cyc("nr ma", v_ma, S_MEMADR, 1'b1);
    cyc("nr mw", v_mw1, S_MEMWRITE, 1'b1);
    cyc("nr next f", v_f1, S_FETCH, 1'b1);
    check("nr done count", 32'(done_cnt), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
